// File: rtl/call_scheduler.sv
// call_scheduler: SCAN-policy floor-call latching and motor sequencing for the freight elevator.
// Define SEVENSEG_EN to add the floor/fault seven-segment outputs (disp_7seg, COMC).
module call_scheduler #(
  parameter int N_FLOORS       = 3,
  parameter int DWELL_CYCLES   = 20,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] call,
  input  logic [N_FLOORS-1:0] fc,
  output logic [1:0]          motor,
  output logic [2:0]          floor,
  output logic [N_FLOORS-1:0] pending,
  output logic                busy,
  output logic                fault
`ifdef SEVENSEG_EN
  ,
  output logic [6:0]          disp_7seg,
  output logic                COMC
`endif
);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int DW = $clog2(DWELL_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_UP    = 3'd1,
    ST_DOWN  = 3'd2,
    ST_DWELL = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  state_t              state_r, state_s;
  logic [2:0]          floor_r, floor_s, fc_idx_s;
  logic [3:0]          fc_cnt_s;
  logic                fc_hot_s, fc_multi_s, new_floor_s, stop_s;
  logic [N_FLOORS-1:0] pending_r, pending_s, drop_s, merged_s, above_s, below_s;
  logic                dir_r, dir_s;
  logic [TW-1:0]       timer_r, timer_s;
  logic [DW-1:0]       dwell_r, dwell_s;
  logic [1:0]          motor_r;
  logic                busy_r, fault_r;

  assign motor   = motor_r;
  assign floor   = floor_r;
  assign pending = pending_r;
  assign busy    = busy_r;
  assign fault   = fault_r;

`ifdef SEVENSEG_EN
  logic [6:0] disp_r;

  // Segment order is {g,f,e,d,c,b,a}; any value outside 1..8 renders as "E".
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd1:    seg_digit = 7'b0000110;
      4'd2:    seg_digit = 7'b1011011;
      4'd3:    seg_digit = 7'b1001111;
      4'd4:    seg_digit = 7'b1100110;
      4'd5:    seg_digit = 7'b1101101;
      4'd6:    seg_digit = 7'b1111101;
      4'd7:    seg_digit = 7'b0000111;
      4'd8:    seg_digit = 7'b1111111;
      default: seg_digit = 7'b1111001;
    endcase
  endfunction

  assign disp_7seg = disp_r;
  assign COMC      = 1'b1;
`endif

  // Limit-switch decode, call latching and SCAN next-state selection.
  always_comb begin
    fc_cnt_s = 4'd0;
    fc_idx_s = 3'd0;
    drop_s   = {N_FLOORS{1'b0}};
    above_s  = {N_FLOORS{1'b0}};
    below_s  = {N_FLOORS{1'b0}};
    for (int k = 0; k < N_FLOORS; k++) begin
      fc_cnt_s = fc_cnt_s + {3'd0, fc[k]};
      if (fc[k]) fc_idx_s = 3'(k);
      else       fc_idx_s = fc_idx_s;
      above_s[k] = pending_r[k] && (3'(k) > floor_r);
      below_s[k] = pending_r[k] && (3'(k) < floor_r);
      drop_s[k]  = fc[k] && (3'(k) == floor_r) && ((state_r == ST_IDLE) || (state_r == ST_DWELL));
    end
    fc_hot_s    = (fc_cnt_s == 4'd1);
    fc_multi_s  = (fc_cnt_s > 4'd1);
    new_floor_s = fc_hot_s && (fc_idx_s != floor_r);
    merged_s    = pending_r | (call & ~drop_s);
    floor_s     = fc_hot_s ? fc_idx_s : floor_r;

    state_s   = state_r;
    pending_s = merged_s;
    dir_s     = dir_r;
    timer_s   = timer_r;
    dwell_s   = dwell_r;
    stop_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fc_hot_s && !new_floor_s && (|(pending_r & fc))) begin
          state_s   = ST_DWELL;
          pending_s = merged_s & ~fc;
          dwell_s   = {DW{1'b0}};
        end else if ((|above_s) && (dir_r || !(|below_s))) begin
          state_s = ST_UP;
          dir_s   = 1'b1;
          timer_s = {TW{1'b0}};
        end else if (|below_s) begin
          state_s = ST_DOWN;
          dir_s   = 1'b0;
          timer_s = {TW{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_UP, ST_DOWN: begin
        // The end floor in the travel direction is always a stop, call or not.
        stop_s = fc_hot_s && ((|(merged_s & fc)) ||
                              ((state_r == ST_UP) ? fc[N_FLOORS-1] : fc[0]));
        if (stop_s) begin
          state_s   = ST_DWELL;
          pending_s = merged_s & ~fc;
          dwell_s   = {DW{1'b0}};
          timer_s   = {TW{1'b0}};
        end else if (new_floor_s) begin
          timer_s = {TW{1'b0}};
        end else if (timer_r >= TIMER_LAST) begin
          state_s = ST_FAULT;
        end else begin
          timer_s = timer_r + TW'(1'b1);
        end
      end
      ST_DWELL: begin
        if (dwell_r >= DWELL_LAST) begin
          state_s = ST_IDLE;
          dwell_s = {DW{1'b0}};
        end else begin
          dwell_s = dwell_r + DW'(1'b1);
        end
      end
      ST_FAULT: begin
        pending_s = pending_r;
      end
      default: begin
        state_s   = ST_FAULT;
        pending_s = pending_r;
      end
    endcase
    if (fc_multi_s) state_s = ST_FAULT;
    else            state_s = state_s;
  end

  // State and registered Moore outputs, decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      floor_r   <= 3'd0;
      pending_r <= {N_FLOORS{1'b0}};
      dir_r     <= 1'b1;
      timer_r   <= {TW{1'b0}};
      dwell_r   <= {DW{1'b0}};
      motor_r   <= 2'b00;
      busy_r    <= 1'b0;
      fault_r   <= 1'b0;
`ifdef SEVENSEG_EN
      disp_r    <= 7'b0000110;
`endif
    end else begin
      state_r   <= state_s;
      floor_r   <= floor_s;
      pending_r <= pending_s;
      dir_r     <= dir_s;
      timer_r   <= timer_s;
      dwell_r   <= dwell_s;
      case (state_s)
        ST_UP:   motor_r <= 2'b01;
        ST_DOWN: motor_r <= 2'b10;
        default: motor_r <= 2'b00;
      endcase
      busy_r    <= (state_s != ST_IDLE);
      fault_r   <= (state_s == ST_FAULT);
`ifdef SEVENSEG_EN
      disp_r    <= (state_s == ST_FAULT) ? 7'b1111001 : seg_digit({1'b0, floor_s} + 4'd1);
`endif
    end
  end

endmodule

// File: tb/tb_call_scheduler.sv
// Self-checking bench for call_scheduler with a simple car model driving the limit switches.
module tb_call_scheduler;
  localparam int NF = 3;
  localparam int DWELL = 4;
  localparam int TMO = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NF-1:0] call = 3'b000;
  logic [NF-1:0] fc = 3'b001;
  logic [1:0] motor;
  logic [2:0] floor;
  logic [NF-1:0] pending;
  logic busy, fault;
`ifdef SEVENSEG_EN
  logic [6:0] disp_7seg;
  logic COMC;
`endif

  int total = 0;
  int bad = 0;
  int exp_q[$];
  int pos_m = 0;
  int travel_m = 0;
  bit auto_car = 1'b1;
  bit arrived = 1'b0;
  logic [1:0] prev_motor = 2'b00;

  call_scheduler #(.N_FLOORS(NF), .DWELL_CYCLES(DWELL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .call(call), .fc(fc), .motor(motor), .floor(floor),
    .pending(pending), .busy(busy), .fault(fault)
`ifdef SEVENSEG_EN
    , .disp_7seg(disp_7seg), .COMC(COMC)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock: sample, score any stop against the expected order, then move the car.
  task automatic step();
    int e;
    @(posedge clk);
    #1;
    if (rst && prev_motor != 2'b00 && motor == 2'b00 && !fault) begin
      arrived = 1'b1;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL stop_order: stopped at floor %0d, no stop expected", floor);
      end else begin
        e = exp_q.pop_front();
        if (floor !== 3'(e)) begin
          bad++;
          $display("FAIL stop_order: stopped at floor %0d, expected %0d", floor, e);
        end
      end
      total++;
      if ((pending & (3'b001 << floor)) !== 3'b000) begin
        bad++;
        $display("FAIL stop_clear: pending=%b at stop floor %0d, bit must be 0", pending, floor);
      end
    end
    prev_motor = motor;
    if (auto_car) begin
      if (motor == 2'b01 || motor == 2'b10) begin
        travel_m++;
        if (travel_m == 1) begin
          fc = 3'b000;
        end else if (travel_m == 3) begin
          pos_m = pos_m + ((motor == 2'b01) ? 1 : -1);
          if (pos_m > NF - 1) pos_m = NF - 1;
          if (pos_m < 0) pos_m = 0;
          travel_m = 0;
          fc = 3'b001 << pos_m;
        end
      end else begin
        travel_m = 0;
        fc = 3'b001 << pos_m;
      end
    end
  endtask

  task automatic pulse_call(input logic [NF-1:0] v);
    call = v;
    step();
    call = 3'b000;
  endtask

  task automatic wait_arrival(input int budget);
    int n;
    arrived = 1'b0;
    for (n = 0; n < budget; n++) begin
      step();
      if (arrived) break;
    end
    total++;
    if (!arrived) begin
      bad++;
      $display("FAIL arrival_timeout: no stop within %0d cycles", budget);
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      step();
      if (!busy && exp_q.size() == 0) break;
    end
    total++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL idle_timeout: busy=%b stops_left=%0d, expected idle with none left", busy, exp_q.size());
    end
  endtask

  task automatic release_reset();
    fc = 3'b001;
    pos_m = 0;
    travel_m = 0;
    prev_motor = 2'b00;
    auto_car = 1'b1;
    call = 3'b000;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    total += 5;
    if (motor !== 2'b00) begin bad++; $display("FAIL rst_motor: got %b want 00", motor); end
    if (floor !== 3'd0) begin bad++; $display("FAIL rst_floor: got %0d want 0", floor); end
    if (pending !== 3'b000) begin bad++; $display("FAIL rst_pending: got %b want 000", pending); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (fault !== 1'b0) begin bad++; $display("FAIL rst_fault: got %b want 0", fault); end
`ifdef SEVENSEG_EN
    total++;
    if (disp_7seg !== 7'b0000110) begin bad++; $display("FAIL rst_disp: got %b want 0000110", disp_7seg); end
`endif
    release_reset();
  endtask

  task automatic test_up_to_top();
    int n;
    pulse_call(3'b100);
    total += 2;
    if (pending !== 3'b100) begin bad++; $display("FAIL up_pending: got %b want 100", pending); end
    if (motor !== 2'b00) begin bad++; $display("FAIL up_latency: motor %b one edge after call, want 00", motor); end
    exp_q.push_back(2);
    step();
    total++;
    if (motor !== 2'b01) begin bad++; $display("FAIL up_motor: got %b want 01", motor); end
    wait_arrival(100);
    total += 3;
    if (motor !== 2'b00) begin bad++; $display("FAIL up_stop_motor: got %b want 00", motor); end
    if (floor !== 3'd2) begin bad++; $display("FAIL up_floor: got %0d want 2", floor); end
    if (pending !== 3'b000) begin bad++; $display("FAIL up_clear: got %b want 000", pending); end
`ifdef SEVENSEG_EN
    total++;
    if (disp_7seg !== 7'b1001111) begin bad++; $display("FAIL up_disp: got %b want 1001111", disp_7seg); end
`endif
    n = 0;
    while (busy && n < 20) begin
      n++;
      step();
    end
    total++;
    if (n != DWELL) begin bad++; $display("FAIL dwell_len: busy for %0d cycles after stop, want %0d", n, DWELL); end
  endtask

  task automatic test_down_pass();
    exp_q.push_back(0);
    pulse_call(3'b001);
    run_until_idle(100);
    total++;
    if (floor !== 3'd0) begin bad++; $display("FAIL down_floor: got %0d want 0", floor); end
  endtask

  task automatic test_same_floor();
    pulse_call(3'b001);
    total++;
    if (pending !== 3'b000) begin bad++; $display("FAIL same_pending: got %b want 000", pending); end
    repeat (3) step();
    total += 2;
    if (motor !== 2'b00) begin bad++; $display("FAIL same_motor: got %b want 00", motor); end
    if (busy !== 1'b0) begin bad++; $display("FAIL same_busy: got %b want 0", busy); end
  endtask

  task automatic test_scan_order();
    exp_q.push_back(1);
    exp_q.push_back(2);
    pulse_call(3'b110);
    wait_arrival(100);
    total++;
    if (pending !== 3'b100) begin bad++; $display("FAIL scan_pending: got %b want 100", pending); end
    exp_q.push_back(0);
    pulse_call(3'b001);
    total++;
    if (pending !== 3'b101) begin bad++; $display("FAIL scan_dwell_latch: got %b want 101", pending); end
    run_until_idle(300);
    total += 2;
    if (floor !== 3'd0) begin bad++; $display("FAIL scan_floor: got %0d want 0", floor); end
    if (pending !== 3'b000) begin bad++; $display("FAIL scan_clear: got %b want 000", pending); end
  endtask

  task automatic test_timeout();
    int n;
    auto_car = 1'b0;
    pulse_call(3'b100);
    step();
    total++;
    if (motor !== 2'b01) begin bad++; $display("FAIL to_motor: got %b want 01", motor); end
    fc = 3'b000;
    n = 0;
    while (!fault && n < 100) begin
      step();
      n++;
    end
    total += 2;
    if (n != TMO) begin bad++; $display("FAIL to_cycles: fault after %0d cycles, want %0d", n, TMO); end
    if (motor !== 2'b00) begin bad++; $display("FAIL to_motor_off: got %b want 00", motor); end
    pulse_call(3'b010);
    step();
    total += 2;
    if (pending !== 3'b100) begin bad++; $display("FAIL to_frozen: got %b want 100", pending); end
    if (fault !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", fault); end
    #2 rst = 1'b0;
    #1;
    total += 4;
    if (motor !== 2'b00) begin bad++; $display("FAIL to_rst_motor: got %b want 00", motor); end
    if (fault !== 1'b0) begin bad++; $display("FAIL to_rst_fault: got %b want 0", fault); end
    if (pending !== 3'b000) begin bad++; $display("FAIL to_rst_pending: got %b want 000", pending); end
    if (busy !== 1'b0) begin bad++; $display("FAIL to_rst_busy: got %b want 0", busy); end
    release_reset();
  endtask

  task automatic test_reset_mid_move();
    auto_car = 1'b0;
    pulse_call(3'b010);
    step();
    total++;
    if (motor !== 2'b01) begin bad++; $display("FAIL mid_motor: got %b want 01", motor); end
    #2 rst = 1'b0;
    #1;
    total++;
    if (motor !== 2'b00) begin bad++; $display("FAIL mid_rst_motor: got %b want 00", motor); end
    release_reset();
  endtask

  task automatic test_multi_fc();
    auto_car = 1'b0;
    fc = 3'b011;
    step();
    total += 2;
    if (fault !== 1'b1) begin bad++; $display("FAIL multi_fault: got %b want 1", fault); end
    if (motor !== 2'b00) begin bad++; $display("FAIL multi_motor: got %b want 00", motor); end
`ifdef SEVENSEG_EN
    total++;
    if (disp_7seg !== 7'b1111001) begin bad++; $display("FAIL multi_disp: got %b want 1111001", disp_7seg); end
`endif
    #2 rst = 1'b0;
    #1;
    total++;
    if (fault !== 1'b0) begin bad++; $display("FAIL multi_rst: got %b want 0", fault); end
`ifdef SEVENSEG_EN
    total++;
    if (disp_7seg !== 7'b0000110) begin bad++; $display("FAIL multi_rst_disp: got %b want 0000110", disp_7seg); end
`endif
    release_reset();
  endtask

  initial begin
    test_reset();
    test_up_to_top();
    test_down_pass();
    test_same_floor();
    test_scan_order();
    test_timeout();
    test_reset_mid_move();
    test_multi_fc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
